// File: rtl/cmac_reg_pkg.sv
// Shared encodings for the CMAC multi-group register block: group states,
// register offsets and error bit positions.
package cmac_reg_pkg;

    typedef enum logic [1:0] {
        GRP_IDLE    = 2'd0,
        GRP_PENDING = 2'd1,
        GRP_RUNNING = 2'd2
    } grp_state_e;

    localparam logic [11:0] OFF_S_STATUS    = 12'h000;
    localparam logic [11:0] OFF_S_POINTER   = 12'h004;
    localparam logic [11:0] OFF_D_OP_ENABLE = 12'h008;
    localparam logic [11:0] OFF_S_ERR       = 12'h00C;

    localparam int ERR_ENABLE_BIT = 0;
    localparam int ERR_DONE_BIT   = 1;

endpackage

// File: rtl/cmac_reg_grp_fsm.sv
// Single register group state machine: IDLE -> PENDING -> RUNNING -> IDLE.
module cmac_reg_grp_fsm
    import cmac_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       set_pending,
    input  logic       launch,
    input  logic       done,
    output logic [1:0] state
);

    grp_state_e state_r;
    grp_state_e state_nxt_s;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= GRP_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state decode; each transition only fires from its own source state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            GRP_IDLE: begin
                if (set_pending) state_nxt_s = GRP_PENDING;
                else             state_nxt_s = GRP_IDLE;
            end
            GRP_PENDING: begin
                if (launch) state_nxt_s = GRP_RUNNING;
                else        state_nxt_s = GRP_PENDING;
            end
            GRP_RUNNING: begin
                if (done) state_nxt_s = GRP_IDLE;
                else      state_nxt_s = GRP_RUNNING;
            end
            default: state_nxt_s = GRP_IDLE;
        endcase
    end

    assign state = state_r;

endmodule

// File: rtl/cmac_reg_multi_group_seq.sv
// CMAC register block with NUM_GROUPS groups: software fills groups at the
// producer pointer, hardware launches them in order at the consumer pointer.
module cmac_reg_multi_group_seq
    import cmac_reg_pkg::*;
#(
    parameter int          NUM_GROUPS = 2,
    parameter logic [11:0] BASE_ADDR  = 12'h000,
    localparam int         PTR_W      = $clog2(NUM_GROUPS)
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic [11:0]             reg_offset,
    input  logic [31:0]             reg_wr_data,
    input  logic                    reg_wr_en,
    output logic [31:0]             reg_rd_data,
    output logic [PTR_W-1:0]        producer,
    output logic [PTR_W-1:0]        consumer,
    output logic                    op_start,
    output logic [PTR_W-1:0]        op_group,
    input  logic                    op_done,
    output logic [2*NUM_GROUPS-1:0] group_status,
    output logic                    done_irq
);

    localparam logic [11:0]      ADDR_STATUS  = BASE_ADDR + OFF_S_STATUS;
    localparam logic [11:0]      ADDR_POINTER = BASE_ADDR + OFF_S_POINTER;
    localparam logic [11:0]      ADDR_ENABLE  = BASE_ADDR + OFF_D_OP_ENABLE;
    localparam logic [11:0]      ADDR_ERR     = BASE_ADDR + OFF_S_ERR;
    localparam logic [PTR_W-1:0] LAST_GRP     = PTR_W'(NUM_GROUPS - 1);
    localparam logic [PTR_W-1:0] ONE_PTR      = PTR_W'(1);
    localparam logic [PTR_W:0]   NUM_GRP_W    = (PTR_W + 1)'(NUM_GROUPS);

    logic [PTR_W-1:0]        producer_r;
    logic [PTR_W-1:0]        consumer_r;
    logic                    busy_r;
    logic                    op_start_r;
    logic                    done_irq_r;
    logic [1:0]              err_r;

    logic [1:0]              grp_state_s [NUM_GROUPS];
    logic [2*NUM_GROUPS-1:0] group_status_s;
    logic                    enable_req_s;
    logic                    enable_ok_s;
    logic                    enable_bad_s;
    logic                    launch_s;
    logic                    done_ok_s;
    logic                    done_bad_s;
    logic [PTR_W-1:0]        ptr_wr_s;
    logic [PTR_W-1:0]        ptr_wrapped_s;
    logic [1:0]              err_set_s;
    logic [1:0]              err_clr_s;
    logic [1:0]              err_nxt_s;
    logic [31:0]             rd_data_s;
    logic                    unused_wr_data_s;

    // enable is judged against the pre-edge state, so a coincident op_done cannot free it
    assign enable_req_s = reg_wr_en && (reg_offset == ADDR_ENABLE) && reg_wr_data[0];
    assign enable_ok_s  = enable_req_s && (grp_state_s[producer_r] == GRP_IDLE);
    assign enable_bad_s = enable_req_s && (grp_state_s[producer_r] != GRP_IDLE);
    assign launch_s     = !busy_r && (grp_state_s[consumer_r] == GRP_PENDING);
    assign done_ok_s    = op_done && busy_r;
    assign done_bad_s   = op_done && !busy_r;

    assign unused_wr_data_s = ^reg_wr_data[31:2];

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        cmac_reg_grp_fsm u_fsm (
            .clk         (nvdla_core_clk),
            .rst         (nvdla_core_rst),
            .set_pending (enable_ok_s && (producer_r == PTR_W'(g))),
            .launch      (launch_s && (consumer_r == PTR_W'(g))),
            .done        (done_ok_s && (consumer_r == PTR_W'(g))),
            .state       (grp_state_s[g])
        );
        assign group_status_s[2*g +: 2] = grp_state_s[g];
    end

    // producer write value folded into range by compare-and-subtract
    always_comb begin
        ptr_wr_s = reg_wr_data[PTR_W-1:0];
        if ({1'b0, ptr_wr_s} >= NUM_GRP_W) begin
            ptr_wrapped_s = ptr_wr_s - NUM_GRP_W[PTR_W-1:0];
        end else begin
            ptr_wrapped_s = ptr_wr_s;
        end
    end

    // error flags: W1C clear, with a coincident set taking priority
    always_comb begin
        err_set_s                 = 2'b00;
        err_set_s[ERR_ENABLE_BIT] = enable_bad_s;
        err_set_s[ERR_DONE_BIT]   = done_bad_s;
        if (reg_wr_en && (reg_offset == ADDR_ERR)) begin
            err_clr_s = reg_wr_data[1:0];
        end else begin
            err_clr_s = 2'b00;
        end
        err_nxt_s = (err_r & ~err_clr_s) | err_set_s;
    end

    // pointers, busy flag, launch/irq pulses and error register
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            producer_r <= {PTR_W{1'b0}};
            consumer_r <= {PTR_W{1'b0}};
            busy_r     <= 1'b0;
            op_start_r <= 1'b0;
            done_irq_r <= 1'b0;
            err_r      <= 2'b00;
        end else begin
            if (reg_wr_en && (reg_offset == ADDR_POINTER)) begin
                producer_r <= ptr_wrapped_s;
            end
            if (done_ok_s) begin
                consumer_r <= (consumer_r == LAST_GRP) ? {PTR_W{1'b0}} : consumer_r + ONE_PTR;
            end
            if (launch_s) begin
                busy_r <= 1'b1;
            end else if (done_ok_s) begin
                busy_r <= 1'b0;
            end
            op_start_r <= launch_s;
            done_irq_r <= done_ok_s;
            err_r      <= err_nxt_s;
        end
    end

    // combinational read mux; unmapped offsets read as zero
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (reg_offset)
            ADDR_STATUS:  rd_data_s[2*NUM_GROUPS-1:0] = group_status_s;
            ADDR_POINTER: begin
                rd_data_s[PTR_W-1:0]   = producer_r;
                rd_data_s[16 +: PTR_W] = consumer_r;
            end
            ADDR_ENABLE:  rd_data_s[0]   = (grp_state_s[producer_r] != GRP_IDLE);
            ADDR_ERR:     rd_data_s[1:0] = err_r;
            default:      rd_data_s      = 32'h0000_0000;
        endcase
    end

    assign reg_rd_data  = rd_data_s;
    assign producer     = producer_r;
    assign consumer     = consumer_r;
    assign op_start     = op_start_r;
    assign op_group     = consumer_r;
    assign group_status = group_status_s;
    assign done_irq     = done_irq_r;

endmodule

// File: tb/tb_cmac_reg_multi_group_seq.sv
// Directed bench for cmac_reg_multi_group_seq with NUM_GROUPS=2.
module tb_cmac_reg_multi_group_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] reg_offset = 12'h000;
    logic [31:0] reg_wr_data = 32'h0;
    logic        reg_wr_en = 1'b0;
    logic [31:0] reg_rd_data;
    logic        producer;
    logic        consumer;
    logic        op_start;
    logic        op_group;
    logic        op_done = 1'b0;
    logic [3:0]  group_status;
    logic        done_irq;

    int errors = 0;
    int checks = 0;

    cmac_reg_multi_group_seq #(.NUM_GROUPS(2), .BASE_ADDR(12'h000)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .reg_offset     (reg_offset),
        .reg_wr_data    (reg_wr_data),
        .reg_wr_en      (reg_wr_en),
        .reg_rd_data    (reg_rd_data),
        .producer       (producer),
        .consumer       (consumer),
        .op_start       (op_start),
        .op_group       (op_group),
        .op_done        (op_done),
        .group_status   (group_status),
        .done_irq       (done_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] off, input logic [31:0] exp);
        reg_offset = off;
        #1;
        chk(tag, reg_rd_data, exp);
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] data);
        reg_offset  = off;
        reg_wr_data = data;
        reg_wr_en   = 1'b1;
        @(negedge clk);
        reg_wr_en   = 1'b0;
    endtask

    task automatic pulse_done();
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
    endtask

    task automatic wr_with_done(input logic [11:0] off, input logic [31:0] data);
        reg_offset  = off;
        reg_wr_data = data;
        reg_wr_en   = 1'b1;
        op_done     = 1'b1;
        @(negedge clk);
        reg_wr_en   = 1'b0;
        op_done     = 1'b0;
    endtask

    initial begin
        // reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("rst_status", 12'h000, 32'h0);
        rd_chk("rst_pointer", 12'h004, 32'h0);
        rd_chk("rst_err", 12'h00C, 32'h0);
        chk("rst_op_start", op_start, 0);
        chk("rst_group_status", group_status, 0);
        rd_chk("unmapped_rd", 12'h010, 32'h0);

        // single group launch and completion
        wr(12'h008, 32'h1);
        chk("g0_pending", group_status, 4'b0001);
        chk("g0_no_start_yet", op_start, 0);
        @(negedge clk);
        chk("g0_running", group_status, 4'b0010);
        chk("g0_op_start", op_start, 1);
        chk("g0_op_group", op_group, 0);
        rd_chk("g0_enable_rd", 12'h008, 32'h1);
        @(negedge clk);
        chk("g0_start_one_cycle", op_start, 0);
        pulse_done();
        chk("g0_done_status", group_status, 4'b0000);
        chk("g0_done_consumer", consumer, 1);
        chk("g0_done_irq", done_irq, 1);
        rd_chk("g0_done_pointer", 12'h004, 32'h0001_0000);
        @(negedge clk);
        chk("g0_irq_one_cycle", done_irq, 0);

        // in-order launches; group0 waits while consumer sits on group1
        wr(12'h008, 32'h1);
        chk("ooo_g0_pending", group_status, 4'b0001);
        @(negedge clk);
        chk("ooo_g0_held", group_status, 4'b0001);
        chk("ooo_no_start", op_start, 0);
        wr(12'h004, 32'h1);
        wr(12'h008, 32'h1);
        chk("ooo_both_pending", group_status, 4'b0101);
        @(negedge clk);
        chk("ooo_g1_running", group_status, 4'b1001);
        chk("ooo_g1_start", op_start, 1);
        chk("ooo_g1_group", op_group, 1);
        pulse_done();
        chk("ooo_g1_done", group_status, 4'b0001);
        chk("ooo_consumer_wrap", consumer, 0);
        chk("ooo_g1_irq", done_irq, 1);
        @(negedge clk);
        chk("ooo_g0_running", group_status, 4'b0010);
        chk("ooo_g0_start", op_start, 1);
        chk("ooo_g0_group", op_group, 0);
        rd_chk("ooo_pointer", 12'h004, 32'h0000_0001);

        // enable on a RUNNING group and W1C clear
        wr(12'h004, 32'h0);
        wr(12'h008, 32'h1);
        chk("busy_en_status", group_status, 4'b0010);
        rd_chk("busy_en_err", 12'h00C, 32'h1);
        wr(12'h00C, 32'h1);
        rd_chk("err_w1c", 12'h00C, 32'h0);

        // producer write of 3 truncates to 1; consumer field is read-only
        wr(12'h004, 32'h0001_0003);
        rd_chk("ptr_wrap", 12'h004, 32'h0000_0001);

        // op_done plus enable of a different idle group
        wr_with_done(12'h008, 32'h1);
        chk("sim_diff_status", group_status, 4'b0100);
        chk("sim_diff_irq", done_irq, 1);
        rd_chk("sim_diff_pointer", 12'h004, 32'h0001_0001);
        rd_chk("sim_diff_err", 12'h00C, 32'h0);
        @(negedge clk);
        chk("sim_diff_g1_run", group_status, 4'b1000);
        chk("sim_diff_g1_start", op_start, 1);
        chk("sim_diff_g1_group", op_group, 1);
        pulse_done();
        chk("sim_diff_g1_done", group_status, 4'b0000);
        rd_chk("sim_diff_wrap", 12'h004, 32'h0000_0001);

        // op_done while idle, coincident with a W1C of the same bit
        wr_with_done(12'h00C, 32'h2);
        rd_chk("idle_done_err", 12'h00C, 32'h2);
        chk("idle_done_status", group_status, 4'b0000);
        chk("idle_done_no_irq", done_irq, 0);
        chk("idle_done_consumer", consumer, 0);
        wr(12'h00C, 32'h2);
        rd_chk("idle_done_clr", 12'h00C, 32'h0);

        // op_done plus enable of the same (RUNNING) group
        wr(12'h004, 32'h0);
        wr(12'h008, 32'h1);
        chk("sim_same_pending", group_status, 4'b0001);
        @(negedge clk);
        chk("sim_same_running", group_status, 4'b0010);
        wr_with_done(12'h008, 32'h1);
        chk("sim_same_status", group_status, 4'b0000);
        rd_chk("sim_same_err", 12'h00C, 32'h1);
        rd_chk("sim_same_pointer", 12'h004, 32'h0001_0000);
        wr(12'h00C, 32'h1);

        // reset while group1 is RUNNING with an error pending
        wr(12'h004, 32'h1);
        wr(12'h008, 32'h1);
        chk("mid_pending", group_status, 4'b0100);
        @(negedge clk);
        chk("mid_running", group_status, 4'b1000);
        chk("mid_start", op_start, 1);
        wr(12'h008, 32'h1);
        rd_chk("mid_err", 12'h00C, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_status", group_status, 4'b0000);
        chk("mid_rst_start", op_start, 0);
        chk("mid_rst_irq", done_irq, 0);
        chk("mid_rst_producer", producer, 0);
        chk("mid_rst_consumer", consumer, 0);
        rd_chk("mid_rst_pointer", 12'h004, 32'h0);
        rd_chk("mid_rst_err", 12'h00C, 32'h0);
        rd_chk("mid_rst_enable", 12'h008, 32'h0);
        @(negedge clk);
        chk("mid_rst_no_spurious", op_start, 0);
        chk("mid_rst_status2", group_status, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
